// File: rtl/capture_dump_if.sv
// capture_dump_if -- bus bundle for the capture read-side dump engine.
// Groups the dump control, RAMqueue read port and transmit handshake.
//   start_rd   : pulse, begin a dump (engine side input)
//   start_addr : oldest sample address
//   raddr      : RAMqueue read address (engine output)
//   rdata      : RAMqueue read data, valid 1 clk after raddr
//   tx_data    : byte to transmitter, tx_valid/tx_ready handshake
//   busy       : engine not idle
//   read_done  : 1-clk pulse after the last byte is accepted
// master = the dump engine, slave = the environment (RAM + transmitter + control).
interface capture_dump_if #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
);
    logic            start_rd;
    logic [LOG2-1:0] start_addr;
    logic [LOG2-1:0] raddr;
    logic [7:0]      rdata;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            read_done;

    modport master (
        input  start_rd, start_addr, rdata, tx_ready,
        output raddr, tx_data, tx_valid, busy, read_done
    );

    modport slave (
        output start_rd, start_addr, rdata, tx_ready,
        input  raddr, tx_data, tx_valid, busy, read_done
    );
endinterface

// File: rtl/capture_dump.sv
// capture_dump -- read-side engine for the channel-capture circular RAMqueue.
// On start_rd it walks all ENTRIES samples from start_addr (wrapping modulo
// ENTRIES), absorbing the RAM's 1-cycle read latency, and sends each byte over
// a valid/ready handshake.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : capture_dump_if.master (start_rd, start_addr, raddr, rdata,
//          tx_data, tx_valid, tx_ready, busy, read_done)
module capture_dump #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic          clk,
    input  logic          rst,
    capture_dump_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    state_t          state_q, state_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [LOG2-1:0] count_q, count_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_rd) begin
                    // Out-of-range start addresses fall back to the first entry.
                    raddr_d = (32'(bus.start_addr) >= ENTRIES) ? '0 : bus.start_addr;
                    count_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = SEND;
            SEND: begin
                if (bus.tx_ready) begin
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                        // Compare-and-zero wrap: depth need not be a power of two.
                        raddr_d = (raddr_q == LAST) ? '0 : raddr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; tx_data follows rdata directly since raddr is frozen in SEND.
    always_comb begin
        bus.raddr     = raddr_q;
        bus.tx_valid  = (state_q == SEND);
        bus.tx_data   = (state_q == SEND) ? bus.rdata : '0;
        bus.busy      = (state_q != IDLE);
        bus.read_done = (state_q == DONE);
    end

endmodule
